dmux_4way: RTL and testbench
============================

DMUX_4WAY -- requirements
Module: dmux_4way

Interface
REQ-001 Parameter WIDTH, default 1: bit width of the data input and of every data output.
REQ-002 Parameter CNT_W, default 8: width of each per-channel routing counter.
REQ-003 clk  input  1  single clock; all registers update on its rising edge only.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in  input  WIDTH  data to be routed.
REQ-006 sel  input  2  channel select, unsigned: 0=a, 1=b, 2=c, 3=d.
REQ-007 en  input  1  capture enable for the registered outputs and counters.
REQ-008 a, b, c, d  output  WIDTH each  combinational demux outputs.
REQ-009 a_q, b_q, c_q, d_q  output  WIDTH each  registered demux outputs.
REQ-010 vld_q  output  1  registered outputs hold a capture from the previous enabled cycle.
REQ-011 cnt_a, cnt_b, cnt_c, cnt_d  output  CNT_W each  saturating routing counters.

Function
REQ-012 The selected output SHALL equal in; the three unselected outputs SHALL be all-zero (sel=0: a=in; sel=1: b=in; sel=2: c=in; sel=3: d=in).
REQ-013 The a..d outputs SHALL be purely combinational, with zero latency, and SHALL be unaffected by clk, rst and en.
REQ-014 The logic SHALL operate bitwise per data bit; for example, with WIDTH>1 and sel=2, c=in and a=b=d=0.
REQ-015 sel bit 1 SHALL select the {a,b} pair versus the {c,d} pair; sel bit 0 SHALL select the first versus the second output within that pair.
REQ-016 When en=1 and rst=0, each of a_q..d_q SHALL load its combinational counterpart at the rising edge, giving 1-cycle latency.
REQ-017 When en=0 and rst=0, a_q..d_q SHALL hold their values.
REQ-018 vld_q SHALL be loaded with en at every rising edge while rst=0.
REQ-019 Each counter SHALL increment by 1 at a rising edge when en=1, rst=0, its channel is selected and in is nonzero (any bit set).
REQ-020 Each counter SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-021 When en=0, no counter SHALL change.
REQ-022 At most one counter SHALL change per cycle.
REQ-023 A change of sel or in between clock edges SHALL affect only a..d; the registered state SHALL reflect only the values present at the rising edge.
REQ-024 If X/Z appears on sel, the outputs are don't-care; no X-propagation behaviour beyond standard synthesis semantics is required.

Reset
REQ-025 When rst=1 at a rising edge, a_q..d_q, vld_q and cnt_a..cnt_d SHALL become 0.
REQ-026 rst SHALL take priority over en.
REQ-027 Asserting rst in the middle of operation SHALL clear all registered state in that cycle.
REQ-028 rst SHALL NOT affect the combinational outputs a..d.
REQ-029 Registered state is undefined before the first reset edge; the bench SHALL apply reset first.

Verification
REQ-030 Combinational sweep: with in=0 and sel=0,1,2,3, a,b,c,d SHALL all be 0. With in=1 and sel=0,1,2,3, the outputs (a,b,c,d) SHALL be 1000, 0100, 0010 and 0001 respectively.
REQ-031 Registered path: rst=1 for one edge, then en=1, in=1, sel=3. After the next edge d_q=1, a_q=b_q=c_q=0, vld_q=1 and cnt_d=1.
REQ-032 Hold: the state of REQ-031, then en=0, sel=0, in=1 for 3 edges. a_q..d_q and the counters SHALL be unchanged, vld_q=0, and a=1 combinationally.
REQ-033 Saturation: CNT_W=2, en=1, in=1, sel=1 for 5 edges. cnt_b SHALL read 1, 2, 3, 3, 3 and the other counters SHALL stay 0.
REQ-034 Reset priority: the state of REQ-033, then rst=1 and en=1 at one edge. All counters, all *_q outputs and vld_q SHALL be 0, and b=1 combinationally.
REQ-035 Multi-bit: WIDTH=4, in=4'b1010, sel=2. c SHALL be 4'b1010 and a=b=d=0; with in=0, no counter SHALL increment.

Source files
------------

// File: rtl/dmux_4way.sv
// dmux_4way: 1-to-4 demultiplexer with a zero-latency combinational output
// set, a registered output set and four saturating per-channel routing
// counters.
//
// Ports
//   clk               rising-edge clock for all registers
//   rst               synchronous, active-high reset of all registered state
//   in   [WIDTH-1:0]  data to route
//   sel  [1:0]        channel select: 0=a, 1=b, 2=c, 3=d
//   en               capture enable for a_q..d_q and the counters
//   a..d [WIDTH-1:0]  combinational outputs; selected = in, others = 0
//   a_q..d_q          registered copies of a..d, loaded when en=1
//   vld_q             en as seen at the previous rising edge
//   cnt_a..cnt_d      saturating counts of enabled cycles with nonzero in
module dmux_4way #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       sel,
    input  logic             en,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] b_q,
    output logic [WIDTH-1:0] c_q,
    output logic [WIDTH-1:0] d_q,
    output logic             vld_q,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c,
    output logic [CNT_W-1:0] cnt_d
);

    // Increment that sticks at the all-ones maximum instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Stage 0: combinational routing. sel[1] steers in to the {a,b} or
    // {c,d} pair, sel[0] then picks the first or second member of it.
    logic [WIDTH-1:0] lo_pair;
    logic [WIDTH-1:0] hi_pair;
    logic             nz;

    assign lo_pair = in & {WIDTH{~sel[1]}};
    assign hi_pair = in & {WIDTH{ sel[1]}};
    assign a       = lo_pair & {WIDTH{~sel[0]}};
    assign b       = lo_pair & {WIDTH{ sel[0]}};
    assign c       = hi_pair & {WIDTH{~sel[0]}};
    assign d       = hi_pair & {WIDTH{ sel[0]}};
    assign nz      = |in;

    // Stage 1: registered outputs and counters; only the channel chosen
    // by sel can count, so at most one counter moves per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            d_q   <= '0;
            vld_q <= 1'b0;
            cnt_a <= '0;
            cnt_b <= '0;
            cnt_c <= '0;
            cnt_d <= '0;
        end else begin
            vld_q <= en;
            if (en) begin
                a_q <= a;
                b_q <= b;
                c_q <= c;
                d_q <= d;
                if (nz) begin
                    case (sel)
                        2'd0: cnt_a <= sat_inc(cnt_a);
                        2'd1: cnt_b <= sat_inc(cnt_b);
                        2'd2: cnt_c <= sat_inc(cnt_c);
                        2'd3: cnt_d <= sat_inc(cnt_d);
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_dmux_4way.sv
// Testbench for dmux_4way. Two instances share clk/rst/sel/en:
//   u0: WIDTH=1, CNT_W=8 (defaults)
//   u1: WIDTH=4, CNT_W=2 (multi-bit data, fast saturation)
// A channel-indexed reference model predicts registered state.
module tb_dmux_4way;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en;
    logic [1:0] sel;
    logic [0:0] in0;
    logic [3:0] in1;

    logic [0:0] c0[4];
    logic [0:0] q0[4];
    logic [7:0] n0[4];
    logic       v0;
    logic [3:0] c1[4];
    logic [3:0] q1[4];
    logic [1:0] n1[4];
    logic       v1;

    dmux_4way u0 (
        .clk(clk), .rst(rst), .in(in0), .sel(sel), .en(en),
        .a(c0[0]), .b(c0[1]), .c(c0[2]), .d(c0[3]),
        .a_q(q0[0]), .b_q(q0[1]), .c_q(q0[2]), .d_q(q0[3]),
        .vld_q(v0),
        .cnt_a(n0[0]), .cnt_b(n0[1]), .cnt_c(n0[2]), .cnt_d(n0[3])
    );

    dmux_4way #(.WIDTH(4), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .in(in1), .sel(sel), .en(en),
        .a(c1[0]), .b(c1[1]), .c(c1[2]), .d(c1[3]),
        .a_q(q1[0]), .b_q(q1[1]), .c_q(q1[2]), .d_q(q1[3]),
        .vld_q(v1),
        .cnt_a(n1[0]), .cnt_b(n1[1]), .cnt_c(n1[2]), .cnt_d(n1[3])
    );

    int total  = 0;
    int passed = 0;

    // Reference model state.
    logic [0:0] mq0[4];
    logic [3:0] mq1[4];
    logic [7:0] mn0[4];
    logic [1:0] mn1[4];
    logic       mv;

    // Channel ch carries x only when it is the selected one.
    function automatic logic [3:0] route(input logic [3:0] x, input logic [1:0] s, input int ch);
        return (int'(s) == ch) ? x : 4'd0;
    endfunction

    // Advance the model using the inputs that will be present at the edge.
    task automatic step_model();
        if (rst) begin
            for (int ch = 0; ch < 4; ch++) begin
                mq0[ch] = '0; mq1[ch] = '0; mn0[ch] = '0; mn1[ch] = '0;
            end
            mv = 1'b0;
        end else begin
            mv = en;
            if (en) begin
                for (int ch = 0; ch < 4; ch++) begin
                    mq0[ch] = route({3'b0, in0}, sel, ch) != 0 ? 1'b1 : 1'b0;
                    mq1[ch] = route(in1, sel, ch);
                end
                if (in0 != 0 && mn0[sel] != 8'hFF) mn0[sel] = mn0[sel] + 8'd1;
                if (in1 != 0 && mn1[sel] != 2'd3)  mn1[sel] = mn1[sel] + 2'd1;
            end
        end
    endtask

    task automatic tick();
        step_model();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; sel = 2'($urandom); in0 = 1'b1; in1 = 4'hF;
        tick();
        rst = 1'b0; en = 1'b0;
        for (int ch = 0; ch < 4; ch++) begin
            total++;
            if (q0[ch] !== 1'b0 || q1[ch] !== 4'd0 || n0[ch] !== 8'd0 || n1[ch] !== 2'd0)
                $display("FAIL reset_ch%0d: q0=%b q1=%h n0=%0d n1=%0d required all 0",
                         ch, q0[ch], q1[ch], n0[ch], n1[ch]);
            else passed++;
        end
        total++;
        if (v0 !== 1'b0 || v1 !== 1'b0) $display("FAIL reset_vld: got %b%b required 00", v0, v1);
        else passed++;
    endtask

    task automatic test_comb_sweep();
        logic [3:0] exp1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s); in0 = 1'b0; in1 = 4'd0;
            #1;
            total++;
            if ({c0[0], c0[1], c0[2], c0[3]} !== 4'b0000)
                $display("FAIL comb_zero sel=%0d: got %b required 0000", s, {c0[0], c0[1], c0[2], c0[3]});
            else passed++;
            in0 = 1'b1; in1 = 4'd1;
            #1;
            exp1 = 4'b1000 >> s;
            total++;
            if ({c0[0], c0[1], c0[2], c0[3]} !== exp1)
                $display("FAIL comb_one sel=%0d: got %b required %b", s, {c0[0], c0[1], c0[2], c0[3]}, exp1);
            else passed++;
        end
        // Multi-bit: every data bit routed independently.
        in1 = 4'b1010; sel = 2'd2;
        #1;
        total++;
        if (c1[2] !== 4'b1010 || c1[0] !== 4'd0 || c1[1] !== 4'd0 || c1[3] !== 4'd0)
            $display("FAIL comb_multibit: a=%b b=%b c=%b d=%b required c=1010 others 0",
                     c1[0], c1[1], c1[2], c1[3]);
        else passed++;
    endtask

    task automatic test_registered();
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0; en = 1'b1; in0 = 1'b1; in1 = 4'd1; sel = 2'd3;
        tick();
        total++;
        if ({q0[0], q0[1], q0[2], q0[3]} !== 4'b0001 || v0 !== 1'b1 || n0[3] !== 8'd1 || n1[3] !== 2'd1)
            $display("FAIL registered: q=%b vld=%b cnt_d=%0d/%0d required 0001 1 1/1",
                     {q0[0], q0[1], q0[2], q0[3]}, v0, n0[3], n1[3]);
        else passed++;
    endtask

    task automatic test_hold();
        en = 1'b0; sel = 2'd0; in0 = 1'b1; in1 = 4'd1;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if ({q0[0], q0[1], q0[2], q0[3]} !== 4'b0001 || q1[3] !== 4'd1 || v0 !== 1'b0)
            $display("FAIL hold_q: q=%b q1d=%h vld=%b required 0001 1 0",
                     {q0[0], q0[1], q0[2], q0[3]}, q1[3], v0);
        else passed++;
        total++;
        if (n0[0] !== 8'd0 || n0[3] !== 8'd1 || n1[0] !== 2'd0 || n1[3] !== 2'd1)
            $display("FAIL hold_cnt: a=%0d d=%0d a1=%0d d1=%0d required 0 1 0 1", n0[0], n0[3], n1[0], n1[3]);
        else passed++;
        total++;
        if (c0[0] !== 1'b1) $display("FAIL hold_comb_a: got %b required 1", c0[0]);
        else passed++;
    endtask

    task automatic test_saturation();
        logic [1:0] exp_sat[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst = 1'b1;
        tick();
        rst = 1'b0; en = 1'b1; in0 = 1'b1; in1 = 4'd1; sel = 2'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (n1[1] !== exp_sat[i] || n0[1] !== 8'(i + 1))
                $display("FAIL saturation edge%0d: cnt_b=%0d/%0d required %0d/%0d",
                         i, n1[1], n0[1], exp_sat[i], i + 1);
            else passed++;
            total++;
            if (n1[0] !== 2'd0 || n1[2] !== 2'd0 || n1[3] !== 2'd0)
                $display("FAIL saturation_others edge%0d: %0d %0d %0d required 0", i, n1[0], n1[2], n1[3]);
            else passed++;
        end
    endtask

    task automatic test_reset_priority();
        rst = 1'b1; en = 1'b1; sel = 2'd1; in0 = 1'b1; in1 = 4'd1;
        tick();
        for (int ch = 0; ch < 4; ch++) begin
            total++;
            if (q0[ch] !== 1'b0 || q1[ch] !== 4'd0 || n0[ch] !== 8'd0 || n1[ch] !== 2'd0)
                $display("FAIL rst_priority_ch%0d: q0=%b q1=%h n0=%0d n1=%0d required all 0",
                         ch, q0[ch], q1[ch], n0[ch], n1[ch]);
            else passed++;
        end
        total++;
        if (v0 !== 1'b0 || c0[1] !== 1'b1 || c1[1] !== 4'd1)
            $display("FAIL rst_priority_vld_comb: vld=%b b=%b b1=%h required 0 1 1", v0, c0[1], c1[1]);
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_zero_in();
        en = 1'b1; in0 = 1'b1; in1 = 4'd1; sel = 2'd2;
        tick();
        in0 = 1'b0; in1 = 4'd0;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            tick();
        end
        total++;
        if (n0[2] !== 8'd1 || n1[2] !== 2'd1 || n0[0] !== 8'd0 || n0[1] !== 8'd0 || n0[3] !== 8'd0)
            $display("FAIL zero_in_cnt: %0d %0d %0d %0d c1=%0d required 0 0 1 0 / 1",
                     n0[0], n0[1], n0[2], n0[3], n1[2]);
        else passed++;
        total++;
        if (q1[2] !== 4'd0 || q0[2] !== 1'b0) $display("FAIL zero_in_q: c_q=%b/%h required 0", q0[2], q1[2]);
        else passed++;
    endtask

    task automatic test_random();
        int errs;
        for (int i = 0; i < 400; i++) begin
            // Values driven early in the cycle only reach the comb outputs.
            sel = 2'($urandom); in0 = 1'($urandom); in1 = 4'($urandom);
            #1;
            errs = 0;
            for (int ch = 0; ch < 4; ch++) begin
                if (c1[ch] !== route(in1, sel, ch)) errs++;
                if ({3'b0, c0[ch]} !== route({3'b0, in0}, sel, ch)) errs++;
            end
            total++;
            if (errs != 0) $display("FAIL random_comb cyc%0d: %0d mismatching outputs for sel=%0d in1=%h", i, errs, sel, in1);
            else passed++;
            // Final values for this edge.
            rst = ($urandom_range(0, 39) == 0);
            en  = ($urandom_range(0, 3) != 0);
            sel = 2'($urandom);
            in0 = 1'($urandom);
            in1 = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            tick();
            errs = 0;
            for (int ch = 0; ch < 4; ch++) begin
                if (q0[ch] !== mq0[ch] || q1[ch] !== mq1[ch]) errs++;
                if (n0[ch] !== mn0[ch] || n1[ch] !== mn1[ch]) errs++;
            end
            if (v0 !== mv || v1 !== mv) errs++;
            total++;
            if (errs != 0)
                $display("FAIL random_state cyc%0d: cnt0=%0d,%0d,%0d,%0d required %0d,%0d,%0d,%0d cnt1=%0d,%0d,%0d,%0d required %0d,%0d,%0d,%0d vld=%b required %b",
                         i, n0[0], n0[1], n0[2], n0[3], mn0[0], mn0[1], mn0[2], mn0[3],
                         n1[0], n1[1], n1[2], n1[3], mn1[0], mn1[1], mn1[2], mn1[3], v0, mv);
            else passed++;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sel = 2'd0; in0 = 1'b0; in1 = 4'd0;
        test_reset();
        test_comb_sweep();
        test_registered();
        test_hold();
        test_saturation();
        test_reset_priority();
        test_zero_in();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
